branch_unit_p: RTL and testbench
================================

Name: branch_unit_p

Overview:
Parametrised successor to the ARM7 branch executor. It executes B, BL and (optionally) BX on one register-file read/write port pair:
- reads PC (and Rm for BX);
- computes the target;
- writes LR (when linking), then PC;
- signals completion with a start/busy/done handshake.

It sits between the decoder and register_file. Address width, offset width, prefetch offset, register indices and register-file read latency are all configurable.

Parameters:
ADDR_W, 32, width of PC/LR/register values
OFFSET_W, 24, width of the signed word offset field
PC_AHEAD, 8, prefetch bias added to PC for taken branches
LINK_INC, 4, value added to PC to form LR and the not-taken PC
PC_IDX, 15, register index of PC
LR_IDX, 14, register index of LR
RF_RD_LAT, 1, cycles from rf_read_en to a valid rf_read_value (1..3)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin operation; sampled only in IDLE
cond  in  1  condition passed (1 = taken)
link  in  1  write LR before branching
exchange  in  1  BX mode (target from Rm); ignored unless BRANCH_BX_EN
offset  in  OFFSET_W  signed word offset
rm  in  4  source register index for BX
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when PC write issued
thumb  out  1  T bit result of last BX (bit0 of Rm); 0 otherwise
rf_write_en  out  1  register write strobe
rf_write_reg  out  4  register index to write
rf_write_value  out  ADDR_W  write data
rf_read_en  out  1  register read strobe (one-cycle pulse)
rf_read_reg  out  4  register index to read
rf_read_value  in  ADDR_W  read data

Behaviour:
- Reset (async, rst_n=0): state=IDLE. busy, done, thumb, rf_write_en and rf_read_en are 0. rf_write_reg, rf_read_reg and rf_write_value are 0. Latched inputs are cleared.
- IDLE: on start=1, latch cond, link, exchange, offset and rm; go RD_PC. start while busy is ignored, not queued.
- RD_PC: rf_read_en=1 for one cycle, rf_read_reg=PC_IDX; go WAIT_PC.
- WAIT_PC: count RF_RD_LAT cycles, then capture pc=rf_read_value.
  - Exchange and cond: go RD_RM.
  - Link and cond: go WR_LR.
  - Otherwise: go WR_PC.
- RD_RM / WAIT_RM: same protocol with rf_read_reg=rm; capture rmv. Then go WR_LR if link, else WR_PC.
- WR_LR: rf_write_en=1, rf_write_reg=LR_IDX, rf_write_value=pc+LINK_INC; go WR_PC.
- WR_PC: rf_write_en=1, rf_write_reg=PC_IDX, rf_write_value=target; go DONE.
- DONE: done=1 for one cycle, busy=0 in the same cycle; return to IDLE. A new start is accepted in the following cycle.
- Target selection:
  - Not taken: pc+LINK_INC.
  - Taken: pc+PC_AHEAD+(sign_extend(offset)<<2).
  - BX taken: {rmv[ADDR_W-1:1],1'b0}, and thumb<=rmv[0] at WR_PC.
- All arithmetic is modulo 2^ADDR_W; wrap-around is silent. offset is sign-extended from bit OFFSET_W-1.
- cond=0 with link=1: no LR write; PC advances by LINK_INC.
- BL with rm=LR_IDX under BX: Rm is read before LR is written (old LR value used).
- Latency for a read-only path with RF_RD_LAT=1: start to done is 4 cycles plus 1 per extra write and per extra read stage.
- rf_read_en and rf_write_en are never high in the same cycle.
- rst_n asserted mid-operation aborts immediately, with no partial write completed after reset.

Optional Feature:
BRANCH_BX_EN:
- Defined: exchange is honoured (RD_RM/WAIT_RM states exist; thumb is updated).
- Undefined: exchange is ignored and treated as 0, thumb is tied 0, and the RM states are not generated.

Test Plan:
1. PC=0x1000; start, cond=0, offset=0 -> one write, PC=0x00001004; LR unchanged; done pulses once.
2. PC=0x1004; start, cond=1, link=0, offset=3 -> PC=0x00001018.
3. PC=0x2000; start, cond=1, link=1, offset=0xFFFFFE -> LR=0x00002004, PC=0x00002000; LR write precedes PC write.
4. BRANCH_BX_EN defined; PC=0x3000, r3=0x00004001; start, exchange=1, rm=3, cond=1 -> PC=0x00004000, thumb=1. Repeat with r3=0x00004000 -> thumb=0.
5. PC=0xFFFFFFF8, cond=1, offset=0 -> PC=0x00000000 (wrap). Run with RF_RD_LAT=3 -> same result, done 2 cycles later.
6. Assert rst_n=0 during WAIT_PC -> all outputs 0 immediately, no register write. Second start while busy -> ignored, only one done.

Source files
------------

// File: rtl/branch_unit_p_if.sv
// rtl/branch_unit_p_if.sv - register-file read/write port pair used by branch_unit_p
interface branch_unit_p_if #(
    parameter int ADDR_W = 32
);
    logic              rf_write_en;
    logic [3:0]        rf_write_reg;
    logic [ADDR_W-1:0] rf_write_value;
    logic              rf_read_en;
    logic [3:0]        rf_read_reg;
    logic [ADDR_W-1:0] rf_read_value;

    // branch unit side: issues reads and writes, receives read data
    modport master (
        output rf_write_en,
        output rf_write_reg,
        output rf_write_value,
        output rf_read_en,
        output rf_read_reg,
        input  rf_read_value
    );

    // register file side
    modport slave (
        input  rf_write_en,
        input  rf_write_reg,
        input  rf_write_value,
        input  rf_read_en,
        input  rf_read_reg,
        output rf_read_value
    );
endinterface

// File: rtl/branch_unit_p.sv
// rtl/branch_unit_p.sv - B/BL executor over one register-file port pair; BX support enabled by BRANCH_BX_EN
module branch_unit_p #(
    parameter int ADDR_W    = 32,
    parameter int OFFSET_W  = 24,
    parameter int PC_AHEAD  = 8,
    parameter int LINK_INC  = 4,
    parameter int PC_IDX    = 15,
    parameter int LR_IDX    = 14,
    parameter int RF_RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                cond,
    input  logic                link,
    input  logic                exchange,
    input  logic [OFFSET_W-1:0] offset,
    input  logic [3:0]          rm,
    output logic                busy,
    output logic                done,
    output logic                thumb,
    branch_unit_p_if.master     rf
);

    localparam logic [3:0]        PC_REG   = 4'(PC_IDX);
    localparam logic [3:0]        LR_REG   = 4'(LR_IDX);
    localparam logic [1:0]        LAT_LAST = 2'(RF_RD_LAT - 1);
    localparam logic [ADDR_W-1:0] AHEAD    = ADDR_W'(PC_AHEAD);
    localparam logic [ADDR_W-1:0] INC      = ADDR_W'(LINK_INC);

`ifdef BRANCH_BX_EN
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_PC   = 3'd1,
        S_WAIT_PC = 3'd2,
        S_WR_LR   = 3'd3,
        S_WR_PC   = 3'd4,
        S_DONE    = 3'd5,
        S_RD_RM   = 3'd6,
        S_WAIT_RM = 3'd7
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_PC   = 3'd1,
        S_WAIT_PC = 3'd2,
        S_WR_LR   = 3'd3,
        S_WR_PC   = 3'd4,
        S_DONE    = 3'd5
    } state_t;
`endif

    state_t                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  cond_q, cond_d;
    logic                  link_q, link_d;
    logic [OFFSET_W-1:0]   offset_q, offset_d;
    logic [ADDR_W-1:0]     pc_q, pc_d;
    logic                  thumb_q, thumb_d;
`ifdef BRANCH_BX_EN
    logic                  exch_q, exch_d;
    logic [3:0]            rm_q, rm_d;
    logic [ADDR_W-1:0]     rmv_q, rmv_d;
`else
    logic                  unused_bx_inputs;
    assign unused_bx_inputs = ^{exchange, rm};
`endif

    logic [ADDR_W-1:0]     off_ext;
    logic [ADDR_W-1:0]     link_val;
    logic [ADDR_W-1:0]     target;
    logic                  bx_taken;

    assign thumb = thumb_q;

    // branch target and link value from the captured PC (and Rm for BX)
    always_comb begin
        off_ext  = ADDR_W'({{ADDR_W{offset_q[OFFSET_W-1]}}, offset_q});
        link_val = pc_q + INC;
`ifdef BRANCH_BX_EN
        bx_taken = cond_q & exch_q;
`else
        bx_taken = 1'b0;
`endif
        if (!cond_q) begin
            target = link_val;
        end else if (bx_taken) begin
`ifdef BRANCH_BX_EN
            target = {rmv_q[ADDR_W-1:1], 1'b0};
`else
            target = link_val;
`endif
        end else begin
            target = pc_q + AHEAD + (off_ext << 2);
        end
    end

    // sequencer: next state, latched operands and register-file strobes
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cond_d   = cond_q;
        link_d   = link_q;
        offset_d = offset_q;
        pc_d     = pc_q;
        thumb_d  = thumb_q;
`ifdef BRANCH_BX_EN
        exch_d   = exch_q;
        rm_d     = rm_q;
        rmv_d    = rmv_q;
`endif
        busy              = 1'b0;
        done              = 1'b0;
        rf.rf_write_en    = 1'b0;
        rf.rf_write_reg   = '0;
        rf.rf_write_value = '0;
        rf.rf_read_en     = 1'b0;
        rf.rf_read_reg    = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cond_d   = cond;
                    link_d   = link;
                    offset_d = offset;
`ifdef BRANCH_BX_EN
                    exch_d   = exchange;
                    rm_d     = rm;
`endif
                    state_d  = S_RD_PC;
                end
            end
            S_RD_PC: begin
                busy          = 1'b1;
                rf.rf_read_en = 1'b1;
                rf.rf_read_reg = PC_REG;
                cnt_d         = '0;
                state_d       = S_WAIT_PC;
            end
            S_WAIT_PC: begin
                busy = 1'b1;
                if (cnt_q == LAT_LAST) begin
                    pc_d  = rf.rf_read_value;
                    cnt_d = '0;
                    if (bx_taken) begin
`ifdef BRANCH_BX_EN
                        state_d = S_RD_RM;
`else
                        state_d = S_WR_PC;
`endif
                    end else if (link_q && cond_q) begin
                        state_d = S_WR_LR;
                    end else begin
                        state_d = S_WR_PC;
                    end
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
`ifdef BRANCH_BX_EN
            S_RD_RM: begin
                busy           = 1'b1;
                rf.rf_read_en  = 1'b1;
                rf.rf_read_reg = rm_q;
                cnt_d          = '0;
                state_d        = S_WAIT_RM;
            end
            S_WAIT_RM: begin
                busy = 1'b1;
                if (cnt_q == LAT_LAST) begin
                    rmv_d   = rf.rf_read_value;
                    cnt_d   = '0;
                    state_d = link_q ? S_WR_LR : S_WR_PC;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
`endif
            S_WR_LR: begin
                busy              = 1'b1;
                rf.rf_write_en    = 1'b1;
                rf.rf_write_reg   = LR_REG;
                rf.rf_write_value = link_val;
                state_d           = S_WR_PC;
            end
            S_WR_PC: begin
                busy              = 1'b1;
                rf.rf_write_en    = 1'b1;
                rf.rf_write_reg   = PC_REG;
                rf.rf_write_value = target;
`ifdef BRANCH_BX_EN
                thumb_d           = bx_taken ? rmv_q[0] : 1'b0;
`else
                thumb_d           = 1'b0;
`endif
                state_d           = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // state and operand registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            cond_q   <= 1'b0;
            link_q   <= 1'b0;
            offset_q <= '0;
            pc_q     <= '0;
            thumb_q  <= 1'b0;
`ifdef BRANCH_BX_EN
            exch_q   <= 1'b0;
            rm_q     <= '0;
            rmv_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cond_q   <= cond_d;
            link_q   <= link_d;
            offset_q <= offset_d;
            pc_q     <= pc_d;
            thumb_q  <= thumb_d;
`ifdef BRANCH_BX_EN
            exch_q   <= exch_d;
            rm_q     <= rm_d;
            rmv_q    <= rmv_d;
`endif
        end
    end

endmodule

// File: tb/tb_branch_unit_p.sv
// tb/tb_branch_unit_p.sv - directed table-driven bench for branch_unit_p (read latency 1 and 3 instances)
module tb_branch_unit_p;

    typedef struct {
        string       name;
        logic        cond;
        logic        link;
        logic        exch;
        logic [23:0] offset;
        logic [3:0]  rm;
        logic [31:0] pc0;
        logic [31:0] rmv0;
        logic [31:0] exp_pc;
        logic        exp_lr_wr;
        logic [31:0] exp_lr;
        logic        exp_thumb;
        int          exp_lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_s  [2];
    logic        cond_s   [2];
    logic        link_s   [2];
    logic        exch_s   [2];
    logic [23:0] offset_s [2];
    logic [3:0]  rm_s     [2];
    logic        busy_s   [2];
    logic        done_s   [2];
    logic        thumb_s  [2];

    logic [31:0] regs [2][16];
    int          checks;
    int          failures;
    vec_t        vecs[$];

    branch_unit_p_if #(.ADDR_W(32)) rf0 ();
    branch_unit_p_if #(.ADDR_W(32)) rf1 ();

    always #5 clk = ~clk;

    branch_unit_p #(.RF_RD_LAT(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .cond(cond_s[0]), .link(link_s[0]),
        .exchange(exch_s[0]), .offset(offset_s[0]), .rm(rm_s[0]), .busy(busy_s[0]),
        .done(done_s[0]), .thumb(thumb_s[0]), .rf(rf0)
    );

    branch_unit_p #(.RF_RD_LAT(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .cond(cond_s[1]), .link(link_s[1]),
        .exchange(exch_s[1]), .offset(offset_s[1]), .rm(rm_s[1]), .busy(busy_s[1]),
        .done(done_s[1]), .thumb(thumb_s[1]), .rf(rf1)
    );

    // register-file read pipelines (latency 1 and 3); stale data reads as DEADBEEF
    logic       rv0;
    logic [3:0] rp0;
    logic [2:0] rv1;
    logic [3:0] rp1 [3];
    always @(posedge clk) begin
        rv0    <= rf0.rf_read_en;
        rp0    <= rf0.rf_read_reg;
        rv1    <= {rv1[1:0], rf1.rf_read_en};
        rp1[0] <= rf1.rf_read_reg;
        rp1[1] <= rp1[0];
        rp1[2] <= rp1[1];
    end
    assign rf0.rf_read_value = rv0    ? regs[0][rp0]    : 32'hDEAD_BEEF;
    assign rf1.rf_read_value = rv1[2] ? regs[1][rp1[2]] : 32'hDEAD_BEEF;

    // write log, done pulse count and read/write overlap monitor
    int          wn [2];
    logic [3:0]  wreg [2][64];
    logic [31:0] wval [2][64];
    int          dn [2];
    int          ovl;
    initial begin
        wn[0] = 0; wn[1] = 0; dn[0] = 0; dn[1] = 0; ovl = 0;
    end
    always @(negedge clk) begin
        if (rf0.rf_write_en) begin
            wreg[0][wn[0] % 64] = rf0.rf_write_reg;
            wval[0][wn[0] % 64] = rf0.rf_write_value;
            wn[0] = wn[0] + 1;
        end
        if (rf1.rf_write_en) begin
            wreg[1][wn[1] % 64] = rf1.rf_write_reg;
            wval[1][wn[1] % 64] = rf1.rf_write_value;
            wn[1] = wn[1] + 1;
        end
        if (done_s[0]) dn[0] = dn[0] + 1;
        if (done_s[1]) dn[1] = dn[1] + 1;
        if (rf0.rf_read_en && rf0.rf_write_en) ovl = ovl + 1;
        if (rf1.rf_read_en && rf1.rf_write_en) ovl = ovl + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic void add(input string n, input logic c, input logic l, input logic x,
                                input logic [23:0] off, input logic [3:0] r, input logic [31:0] pc0,
                                input logic [31:0] rmv0, input logic [31:0] epc, input logic elr,
                                input logic [31:0] lr, input logic eth, input int elat);
        vec_t v;
        v.name = n; v.cond = c; v.link = l; v.exch = x; v.offset = off; v.rm = r;
        v.pc0 = pc0; v.rmv0 = rmv0; v.exp_pc = epc; v.exp_lr_wr = elr; v.exp_lr = lr;
        v.exp_thumb = eth; v.exp_lat = elat;
        vecs.push_back(v);
    endfunction

    // one operation: preset registers, pulse start, wait (bounded) for done
    task automatic do_op(input int i, input vec_t v, output int lat);
        @(negedge clk);
        regs[i][15] = v.pc0;
        if (v.rm != 4'd15) regs[i][v.rm] = v.rmv0;
        start_s[i] = 1'b1; cond_s[i] = v.cond; link_s[i] = v.link;
        exch_s[i] = v.exch; offset_s[i] = v.offset; rm_s[i] = v.rm;
        @(negedge clk);
        start_s[i] = 1'b0;
        lat = 1;
        while (!done_s[i] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_vec(input int i, input vec_t v, input int w0, input int lat);
        int nw;
        nw = wn[i] - w0;
        chk($sformatf("%s_latency", v.name), 64'(lat), 64'(v.exp_lat));
        chk($sformatf("%s_nwrites", v.name), 64'(nw), v.exp_lr_wr ? 64'd2 : 64'd1);
        if (v.exp_lr_wr) begin
            chk($sformatf("%s_lr_reg", v.name), 64'(wreg[i][w0 % 64]), 64'd14);
            chk($sformatf("%s_lr_val", v.name), 64'(wval[i][w0 % 64]), 64'(v.exp_lr));
        end
        chk($sformatf("%s_pc_reg", v.name), 64'(wreg[i][(wn[i] - 1) % 64]), 64'd15);
        chk($sformatf("%s_pc_val", v.name), 64'(wval[i][(wn[i] - 1) % 64]), 64'(v.exp_pc));
        chk($sformatf("%s_thumb", v.name), 64'(thumb_s[i]), 64'(v.exp_thumb));
    endtask

    initial begin
        int   lat;
        int   w0;
        int   d0;
        vec_t v;
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0; cond_s[i] = 1'b0; link_s[i] = 1'b0;
            exch_s[i] = 1'b0; offset_s[i] = '0; rm_s[i] = '0;
            for (int k = 0; k < 16; k++) regs[i][k] = 32'h1111_0000 + 32'(k);
        end
        repeat (3) @(negedge clk);
        chk("reset_outs_lat1", {busy_s[0], done_s[0], thumb_s[0], rf0.rf_write_en, rf0.rf_read_en,
                                rf0.rf_write_reg, rf0.rf_read_reg, rf0.rf_write_value}, 64'd0);
        chk("reset_outs_lat3", {busy_s[1], done_s[1], thumb_s[1], rf1.rf_write_en, rf1.rf_read_en,
                                rf1.rf_write_reg, rf1.rf_read_reg, rf1.rf_write_value}, 64'd0);
        rst_n = 1'b1;

        //   name        c  l  x  offset     rm    pc0            rmv0           exp_pc         lr exp_lr        th lat
        add("not_taken", 1'b0, 1'b0, 1'b0, 24'h000000, 4'd0, 32'h0000_1000, 32'h0,          32'h0000_1004, 1'b0, 32'h0,          1'b0, 4);
        add("b_fwd",     1'b1, 1'b0, 1'b0, 24'h000003, 4'd0, 32'h0000_1004, 32'h0,          32'h0000_1018, 1'b0, 32'h0,          1'b0, 4);
        add("bl_back",   1'b1, 1'b1, 1'b0, 24'hFFFFFE, 4'd0, 32'h0000_2000, 32'h0,          32'h0000_2000, 1'b1, 32'h0000_2004, 1'b0, 5);
        add("bl_nottkn", 1'b0, 1'b1, 1'b0, 24'h000010, 4'd0, 32'h0000_0500, 32'h0,          32'h0000_0504, 1'b0, 32'h0,          1'b0, 4);
        add("b_wrap",    1'b1, 1'b0, 1'b0, 24'h000000, 4'd0, 32'hFFFF_FFF8, 32'h0,          32'h0000_0000, 1'b0, 32'h0,          1'b0, 4);
        add("b_minoff",  1'b1, 1'b0, 1'b0, 24'h800000, 4'd0, 32'h0400_0000, 32'h0,          32'h0200_0008, 1'b0, 32'h0,          1'b0, 4);
        add("b_maxoff",  1'b1, 1'b0, 1'b0, 24'h7FFFFF, 4'd0, 32'h0000_0000, 32'h0,          32'h0200_0004, 1'b0, 32'h0,          1'b0, 4);
`ifdef BRANCH_BX_EN
        add("bx_thumb",  1'b1, 1'b0, 1'b1, 24'h000000, 4'd3, 32'h0000_3000, 32'h0000_4001, 32'h0000_4000, 1'b0, 32'h0,          1'b1, 6);
        add("bx_arm",    1'b1, 1'b0, 1'b1, 24'h000000, 4'd3, 32'h0000_3000, 32'h0000_4000, 32'h0000_4000, 1'b0, 32'h0,          1'b0, 6);
        add("blx_lr",    1'b1, 1'b1, 1'b1, 24'h000000, 4'd14, 32'h0000_3000, 32'h0000_5003, 32'h0000_5002, 1'b1, 32'h0000_3004, 1'b1, 7);
        add("bx_nottkn", 1'b0, 1'b0, 1'b1, 24'h000000, 4'd3, 32'h0000_3000, 32'h0000_4001, 32'h0000_3004, 1'b0, 32'h0,          1'b0, 4);
`else
        add("bx_ignored", 1'b1, 1'b0, 1'b1, 24'h000001, 4'd3, 32'h0000_3000, 32'h0000_4001, 32'h0000_300C, 1'b0, 32'h0,         1'b0, 4);
`endif

        foreach (vecs[n]) begin
            w0 = wn[0];
            do_op(0, vecs[n], lat);
            check_vec(0, vecs[n], w0, lat);
        end

        // wrap branch on the latency-3 instance: same target, two cycles later
        w0 = wn[1];
        v = vecs[4];
        v.name = "b_wrap_lat3";
        v.exp_lat = 6;
        do_op(1, v, lat);
        check_vec(1, v, w0, lat);

        // reset asserted during WAIT_PC of a BL: immediate idle, no write afterwards
        w0 = wn[0];
        @(negedge clk);
        regs[0][15] = 32'h0000_6000;
        start_s[0] = 1'b1; cond_s[0] = 1'b1; link_s[0] = 1'b1; exch_s[0] = 1'b0; offset_s[0] = 24'h4;
        @(negedge clk);
        start_s[0] = 1'b0;
        chk("abort_busy_rd_pc", 64'(busy_s[0]), 64'd1);
        chk("abort_read_en_rd_pc", 64'(rf0.rf_read_en), 64'd1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_outs", {busy_s[0], done_s[0], thumb_s[0], rf0.rf_write_en, rf0.rf_read_en,
                           rf0.rf_write_reg, rf0.rf_read_reg, rf0.rf_write_value}, 64'd0);
        repeat (4) @(negedge clk);
        chk("abort_no_write", 64'(wn[0] - w0), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // second start while busy is ignored; busy drops in the done cycle
        w0 = wn[0];
        d0 = dn[0];
        regs[0][15] = 32'h0000_7000;
        start_s[0] = 1'b1; cond_s[0] = 1'b0; link_s[0] = 1'b0; exch_s[0] = 1'b0; offset_s[0] = 24'h0;
        @(negedge clk);
        start_s[0] = 1'b0;
        @(negedge clk);
        start_s[0] = 1'b1; cond_s[0] = 1'b1; offset_s[0] = 24'h100;
        @(negedge clk);
        start_s[0] = 1'b0;
        @(negedge clk);
        chk("dup_done_cycle", 64'(done_s[0]), 64'd1);
        chk("dup_busy_in_done", 64'(busy_s[0]), 64'd0);
        repeat (8) @(negedge clk);
        chk("dup_done_count", 64'(dn[0] - d0), 64'd1);
        chk("dup_write_count", 64'(wn[0] - w0), 64'd1);
        chk("dup_pc_val", 64'(wval[0][(wn[0] - 1) % 64]), 64'h0000_7004);
        chk("dup_idle_busy", 64'(busy_s[0]), 64'd0);

        chk("no_read_write_overlap", 64'(ovl), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
